// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the VeriRisc CPU.
// Accepts a valid/ready byte stream and writes it into CPU memory from
// address 0 upward while holding the CPU in reset. It releases the CPU
// once the final byte has landed, then tracks the CPU halt output.

module prog_loader #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              cpu_halt,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data,
  output logic              mem_wr,
  output logic              cpu_rst,
  output logic              loading,
  output logic              done,
  output logic              overflow,
  output logic [AWIDTH:0]   load_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_HALTED
  } state_t;

  localparam logic [AWIDTH-1:0] PTR_MAX  = '1;
  localparam logic [AWIDTH-1:0] PTR_ZERO = '0;
  localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH:0]   CNT_ZERO = '0;
  localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_data_q, mem_data_d;
  logic              mem_wr_q, mem_wr_d;
  logic [AWIDTH:0]   load_cnt_q, load_cnt_d;
  logic              overflow_q, overflow_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              loading_q, loading_d;
  logic              accept;

  // A byte is taken only while loading; in_ready is the sole combinational output.
  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid && in_ready;

  // Next-state, write-port and status computation; every output flop is fed from here.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    load_cnt_d = load_cnt_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d    = S_LOAD;
          ptr_d      = PTR_ZERO;
          load_cnt_d = CNT_ZERO;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = in_data;
          load_cnt_d = load_cnt_q + CNT_ONE;
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + PTR_ONE;
          end
          if (in_last) begin
            state_d = S_FLUSH;
          end else if (ptr_q == PTR_MAX) begin
            // Memory is full and the stream is still going: stop taking bytes.
            overflow_d = 1'b1;
            state_d    = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // A restart wins over a halt seen in the same cycle.
        if (start) begin
          state_d    = S_LOAD;
          ptr_d      = PTR_ZERO;
          load_cnt_d = CNT_ZERO;
          overflow_d = 1'b0;
        end else if (cpu_halt) begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of where the FSM is heading.
    done_d    = (state_d == S_RUN) || (state_d == S_HALTED);
    cpu_rst_d = !done_d;
    loading_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
  end

  // State and output registers with asynchronous reset back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_ZERO;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= PTR_ZERO;
      mem_data_q <= '0;
      load_cnt_q <= CNT_ZERO;
      overflow_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      loading_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      load_cnt_q <= load_cnt_d;
      overflow_q <= overflow_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      loading_q  <= loading_d;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign load_cnt = load_cnt_q;
  assign overflow = overflow_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign loading  = loading_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the VeriRisc CPU.
- Accepts a byte stream over a valid/ready handshake and writes it into CPU memory sequentially from address 0.
- Holds the CPU in reset while loading, releases it once the final byte is written, and watches the CPU halt output.
- Drives the memory write port (address/data/write strobe) that the address mux/memory path otherwise owns during run.

Parameters:
- DWIDTH, 8, memory data / instruction width in bits.
- AWIDTH, 5, memory address width; memory depth = 2**AWIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a (re)load.
- in_data  input  DWIDTH  program byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the final byte of the program; sampled with in_valid.
- in_ready  output  1  loader can accept a byte this cycle.
- cpu_halt  input  1  halt output of the CPU.
- mem_addr  output  AWIDTH  write address to memory.
- mem_data  output  DWIDTH  write data to memory.
- mem_wr  output  1  memory write strobe, one cycle per byte.
- cpu_rst  output  1  reset to CPU (high = held in reset).
- loading  output  1  high while in LOAD or FLUSH.
- done  output  1  high in RUN and HALTED.
- overflow  output  1  sticky: stream exceeded memory depth without in_last.
- load_cnt  output  AWIDTH+1  bytes written in the last/current load.

Behaviour:
- States: IDLE, LOAD, FLUSH, RUN, HALTED. All outputs are registered except in_ready, which is (state==LOAD).
- Reset (async, any state): state=IDLE; cpu_rst=1; mem_wr=0; mem_addr=0; mem_data=0; load_cnt=0; overflow=0; done=0; loading=0.
- IDLE: cpu_rst=1. On start, go to LOAD, clear load_cnt and overflow, and set the internal write pointer to 0.
- LOAD: in_ready=1. A byte is accepted when in_valid&in_ready in cycle N.
  - Cycle N+1: mem_wr=1, mem_addr=pointer value at N, mem_data=in_data at N.
  - The pointer increments and load_cnt increments at that edge.
  - mem_wr=0 in any cycle following a non-accept cycle.
  - Throughput is one byte per clock; no internal backpressure.
- LOAD exit, last byte: accepting a byte with in_last=1 moves the FSM to FLUSH. That write appears during FLUSH.
- LOAD exit, overflow: accepting a byte at pointer 2**AWIDTH-1 with in_last=0 writes that byte, sets overflow=1 (sticky until next start), and moves to FLUSH. The pointer does not wrap and no further bytes are accepted.
- FLUSH: exactly one cycle; in_ready=0; cpu_rst stays 1. Next state is RUN, with cpu_rst=0 from the first RUN cycle. The CPU therefore leaves reset 2 cycles after the final byte is accepted.
- RUN: cpu_rst=0, done=1. On cpu_halt=1, go to HALTED. cpu_rst stays 0 so halt state and memory remain inspectable.
- HALTED: done=1, cpu_rst=0. On start, go to LOAD with cpu_rst=1 from the next cycle.
- start in RUN: aborts the CPU; next cycle is LOAD with cpu_rst=1. A pending cpu_halt in the same cycle is ignored (start has priority).
- start in LOAD or FLUSH: ignored.
- in_last without in_valid: ignored.
- start and in_valid in the same cycle in IDLE: the byte is not accepted, because in_ready=0 in IDLE.
- Reset mid-LOAD: immediate return to IDLE. A partial program stays in memory; cpu_rst=1.
- A load of zero bytes is not possible; at least one byte carrying in_last is required.
- load_cnt range is 1..2**AWIDTH. It saturates at 2**AWIDTH on overflow and holds its value until the next start.

Test Plan:
- Basic load: rst, start, stream 0xA1,0xB2,0xC3 (last on 0xC3) back-to-back.
  - Required: writes addr 0,1,2 with those data on consecutive cycles; load_cnt=3.
  - cpu_rst falls 2 cycles after 0xC3 is accepted; done=1.
- Gapped stream: in_valid toggling 1,0,1,0,1 for 3 bytes -> mem_wr pattern 1,0,1,0,1; addresses 0,1,2 with no skipped or duplicated writes.
- Overflow (AWIDTH=5): 33 bytes, none with last -> 32 writes at addr 0..31, overflow=1, load_cnt=32.
  - in_ready=0 after byte 32 is accepted; byte 33 is never accepted; CPU released.
- Halt/reload: after RUN, assert cpu_halt -> HALTED with cpu_rst=0.
  - start -> cpu_rst=1 next cycle; new 2-byte load writes addr 0,1; overflow and load_cnt cleared.
- Abort: start during RUN, with cpu_halt=1 in the same cycle -> state LOAD, cpu_rst=1, HALTED never entered.
- Async reset mid-LOAD after 2 bytes: outputs reset immediately without a clock edge (cpu_rst=1, mem_wr=0, load_cnt=0); a subsequent start reloads cleanly from addr 0.
